// File: rtl/fetch_unit.sv
// fetch_unit: PC walker issuing word reads to mem, buffering returned words
// in a small FIFO and handing {inst, pc} to decode, with single-cycle redirect/flush.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);
   localparam int          AW  = $clog2(DEPTH);
   localparam logic [31:0] RPC = {RESET_PC[31:2], 2'b00};
   localparam logic [AW:0] DP  = (AW+1)'(DEPTH);
   logic [31:0]   pc_q, pc_d, ipc_q, ipc_d;
   logic          infl_q, infl_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [31:0]   word_q [DEPTH];
   logic [31:0]   wpc_q  [DEPTH];
   logic          push, pop;
   // The in-flight word holds a slot, so count + inflight is the credit in use.
   assign mem_read   = !redirect && ((cnt_q + (AW+1)'(infl_q)) < DP);
   assign mem_addr   = pc_q;
   assign mem_write  = 1'b0;
   assign mem_wdata  = '0;
   assign inst_valid = cnt_q != '0;
   assign inst       = word_q[rp_q];
   assign inst_pc    = wpc_q[rp_q];
   assign push       = infl_q && !redirect;
   assign pop        = inst_valid && inst_ready && !redirect;
   always_comb begin
      pc_d   = redirect ? {redirect_pc[31:2], 2'b00} : mem_read ? pc_q + 32'd4 : pc_q;
      ipc_d  = mem_read ? pc_q : ipc_q;
      infl_d = mem_read;
      wp_d   = redirect ? '0 : wp_q + AW'(push);
      rp_d   = redirect ? '0 : rp_q + AW'(pop);
      cnt_d  = redirect ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= RPC;
         ipc_q  <= '0;
         infl_q <= 1'b0;
         wp_q   <= '0;
         rp_q   <= '0;
         cnt_q  <= '0;
      end else begin
         pc_q   <= pc_d;
         ipc_q  <= ipc_d;
         infl_q <= infl_d;
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         cnt_q  <= cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         word_q[wp_q] <= mem_rdata;
         wpc_q[wp_q]  <= ipc_q;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a stream-level reference model for fetch_unit,
// plus a second instance that walks the PC across the 32-bit wrap.
module tb_fetch_unit;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_ready = 1'b1;
   logic [31:0] mem_addr, mem_wdata, inst, inst_pc;
   logic [31:0] mem_rdata = '0;
   logic        mem_read, mem_write, inst_valid;
   logic [31:0] w_addr, w_wdata, w_inst, w_inst_pc;
   logic [31:0] w_rdata = '0;
   logic        w_read, w_write, w_valid;
   logic        w_redirect = 1'b0;
   logic        w_ready = 1'b1;
   logic [31:0] w_rpc = '0;
   int n_chk = 0;
   int n_pass = 0;
   always #5 clk = ~clk;
   fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_read(mem_read),
      .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc));
   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
      .clk(clk), .rst_n(rst_n), .mem_addr(w_addr), .mem_read(w_read),
      .mem_write(w_write), .mem_wdata(w_wdata), .mem_rdata(w_rdata),
      .redirect(w_redirect), .redirect_pc(w_rpc), .inst_valid(w_valid),
      .inst_ready(w_ready), .inst(w_inst), .inst_pc(w_inst_pc));
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return 32'h1000 + (a >> 2);
   endfunction
   // Memory answers the address accepted on an edge during the following cycle.
   always @(posedge clk) begin
      if (mem_read) mem_rdata <= word_at(mem_addr);
      if (w_read) w_rdata <= word_at(w_addr);
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask
   // Reference: since the last flush, words issued = n_iss (consecutive from base),
   // words handed to decode = n_pop; the newest issue is still in flight.
   logic [31:0] base;
   int  n_iss, n_pop, last_iss;
   bit  e_rd, e_v;
   always @(negedge clk) begin
      if (!rst_n) begin
         base = RPC; n_iss = 0; n_pop = 0; last_iss = 0;
         chk("rst_valid", {31'b0, inst_valid}, 32'd0);
         chk("rst_read", {31'b0, mem_read}, {31'b0, !redirect});
         chk("rst_addr", mem_addr, RPC);
         chk("rst_write", {31'b0, mem_write}, 32'd0);
      end else begin
         e_rd = !redirect && (n_iss - n_pop < DEPTH);
         e_v  = (n_iss - last_iss - n_pop) > 0;
         chk("m_read", {31'b0, mem_read}, {31'b0, e_rd});
         chk("m_valid", {31'b0, inst_valid}, {31'b0, e_v});
         chk("m_addr", mem_addr, base + 32'(4 * n_iss));
         chk("m_write", {31'b0, mem_write}, 32'd0);
         chk("m_wdata", mem_wdata, 32'd0);
         if (e_v) begin
            chk("m_inst_pc", inst_pc, base + 32'(4 * n_pop));
            chk("m_inst", inst, word_at(base + 32'(4 * n_pop)));
         end
         if (redirect) begin
            base = {redirect_pc[31:2], 2'b00}; n_iss = 0; n_pop = 0; last_iss = 0;
         end else begin
            if (e_v && inst_ready) n_pop++;
            last_iss = e_rd ? 1 : 0;
            if (e_rd) n_iss++;
         end
      end
   end
   task automatic step();
      @(posedge clk); #1;
   endtask
   initial begin
      #2;
      chk("lit_rst_valid", {31'b0, inst_valid}, 32'd0);
      chk("lit_rst_read", {31'b0, mem_read}, 32'd1);
      step(); step();
      // streaming from reset, plus the wrap instance
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk); chk("lit_e1_valid", {31'b0, inst_valid}, 32'd0);
      @(negedge clk);
      chk("lit_e2_valid", {31'b0, inst_valid}, 32'd1);
      chk("lit_s0_inst", inst, 32'h1000); chk("lit_s0_pc", inst_pc, 32'h0);
      chk("lit_w0_pc", w_inst_pc, 32'hFFFF_FFF8); chk("lit_w0_inst", w_inst, 32'h4000_0FFE);
      @(negedge clk);
      chk("lit_s1_inst", inst, 32'h1001); chk("lit_s1_pc", inst_pc, 32'h4);
      chk("lit_w1_pc", w_inst_pc, 32'hFFFF_FFFC); chk("lit_w1_inst", w_inst, 32'h4000_0FFF);
      @(negedge clk);
      chk("lit_s2_pc", inst_pc, 32'h8);
      chk("lit_w2_pc", w_inst_pc, 32'h0000_0000); chk("lit_w2_inst", w_inst, 32'h1000);
      @(negedge clk);
      chk("lit_w3_pc", w_inst_pc, 32'h0000_0004); chk("lit_w3_inst", w_inst, 32'h1001);
      repeat (6) step();
      // backpressure from reset
      rst_n = 1'b0; inst_ready = 1'b0;
      step(); step();
      rst_n = 1'b1;
      repeat (8) step();
      @(negedge clk);
      chk("lit_bp_read", {31'b0, mem_read}, 32'd0);
      chk("lit_bp_addr", mem_addr, 32'h10);
      chk("lit_bp_pc", inst_pc, 32'h0);
      step(); inst_ready = 1'b1;
      repeat (10) step();
      // redirect while 0xC is in flight and FIFO holds 0/4/8
      rst_n = 1'b0; inst_ready = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (4) step();
      redirect = 1'b1; redirect_pc = 32'h40;
      @(negedge clk);
      chk("lit_rd_read", {31'b0, mem_read}, 32'd0);
      chk("lit_rd_head", inst_pc, 32'h0);
      step(); redirect = 1'b0; inst_ready = 1'b1;
      @(negedge clk);
      chk("lit_r1_valid", {31'b0, inst_valid}, 32'd0);
      chk("lit_r1_addr", mem_addr, 32'h40);
      @(negedge clk); chk("lit_r2_valid", {31'b0, inst_valid}, 32'd0);
      @(negedge clk);
      chk("lit_r3_pc", inst_pc, 32'h40); chk("lit_r3_inst", inst, 32'h1010);
      @(negedge clk);
      chk("lit_r4_pc", inst_pc, 32'h44); chk("lit_r4_inst", inst, 32'h1011);
      repeat (3) step();
      // misaligned redirect coinciding with a ready handshake on a valid head
      redirect = 1'b1; redirect_pc = 32'h43;
      @(negedge clk); chk("lit_mis_head_valid", {31'b0, inst_valid}, 32'd1);
      step(); redirect = 1'b0;
      @(negedge clk); @(negedge clk); @(negedge clk);
      chk("lit_mis_pc", inst_pc, 32'h40); chk("lit_mis_inst", inst, 32'h1010);
      // back-to-back redirects, last one wins
      step(); redirect = 1'b1; redirect_pc = 32'h100;
      step(); redirect_pc = 32'h200;
      step(); redirect = 1'b0;
      repeat (6) step();
      // async reset mid-stream
      @(posedge clk); #3;
      rst_n = 1'b0; #1;
      chk("lit_ar_valid", {31'b0, inst_valid}, 32'd0);
      chk("lit_ar_write", {31'b0, mem_write}, 32'd0);
      chk("lit_ar_addr", mem_addr, 32'h0);
      step(); rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk); chk("lit_ar_e1", {31'b0, inst_valid}, 32'd0);
      @(negedge clk);
      chk("lit_ar_e2", {31'b0, inst_valid}, 32'd1);
      chk("lit_ar_pc", inst_pc, 32'h0);
      repeat (4) step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of decode and in front of the shared `mem` block. Walks a word-aligned program counter, issues read requests to `mem`, and captures returned words into a small FIFO. Presents instructions tagged with their PC to decode through a valid/ready handshake. Supports single-cycle redirect (branch/jump) with flush of buffered and in-flight words.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; bits [1:0] forced to 0.
- `DEPTH`, 4: instruction FIFO entries; power of two, at least 2.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `mem_addr`  out  32  byte address to `mem`; always equals current PC
- `mem_read`  out  1  read request this cycle
- `mem_write`  out  1  constant 0
- `mem_wdata`  out  32  constant 0
- `mem_rdata`  in  32  word for the address accepted on the previous edge
- `redirect`  in  1  load new PC and flush
- `redirect_pc`  in  32  redirect target
- `inst_valid`  out  1  FIFO head valid
- `inst_ready`  in  1  decode accepts head
- `inst`  out  32  instruction word at FIFO head
- `inst_pc`  out  32  byte address of `inst`

## Operation
- State:
  - `pc` (32)
  - `inflight` (1) and `inflight_pc` (32)
  - FIFO of DEPTH {word, pc} entries with read/write pointers and `count` (0..DEPTH)
- Issue condition (combinational): `mem_read = !redirect && (count + inflight < DEPTH)`. The same-cycle pop is not credited.
- On an edge with `mem_read`=1:
  - `inflight`<=1, `inflight_pc`<=pc
  - `pc`<=pc+4, mod 2^32 (wraps FFFF_FFFC -> 0000_0000)
- On an edge with `inflight`=1 and no redirect: push {`mem_rdata`, `inflight_pc`}. `inflight` clears unless a new issue occurs on the same edge.
- Pop on an edge where `inst_valid && inst_ready`. Push and pop on the same edge are both allowed; `count` is unchanged.
- Credit rule guarantees no push into a full FIFO. Popping an empty FIFO cannot occur because `inst_valid` is 0.
- Redirect, sampled at the edge:
  - `pc`<={redirect_pc[31:2],2'b00}
  - `count`<=0 and pointers reset
  - `inflight`<=0; any returning word is discarded
  - No issue and no pop that cycle. The pop is void even if `inst_ready` is 1.
  - Redirect has priority over push, pop and issue.
- Back-to-back redirects: the last one wins; each flushes again.
- `inst`/`inst_pc` are undefined-but-stable while `inst_valid`=0; bench must not check them.
- Reset values (asserted immediately on `rst_n` fall, independent of `clk`):
  - `pc`=RESET_PC with [1:0]=0
  - `inflight`=0, `count`=0
  - `inst_valid`=0
  - `mem_read` follows its equation: 1 during reset if `redirect`=0; `mem` ignores it until reset releases
  - `mem_write`=0, `mem_wdata`=0

## Timing
- Edge E1 = first rising edge after `rst_n` rises: address RESET_PC is issued.
- E2: word captured; `inst_valid`=1 after E2.
- Fetch-to-valid latency is 2 edges from issue.
- Sustained throughput: 1 instruction/cycle with `inst_ready` held 1.
- Backpressure: after at most DEPTH issues with no pops, `mem_read` drops to 0. Issue resumes in the cycle after the first pop frees credit.
- Redirect at edge R:
  - first new issue at R+1
  - new instruction valid after R+2
  - no stale word is ever visible after R
- Reset asserted mid-stream drops `inst_valid` combinationally via async clear. The FIFO is empty after release.

## Test plan
- Streaming: `mem` word at byte addr 4k = 0x1000+k, RESET_PC=0, `inst_ready`=1 -> `inst_valid` rises after E2. `inst`/`inst_pc` = 0x1000/0, 0x1001/4, 0x1002/8… one per cycle, no gaps or duplicates.
- Backpressure: `inst_ready`=0 from reset -> exactly 4 entries buffered, `mem_read`=0, `pc`=0x10. Set `inst_ready`=1 -> sequence 0x1000..0x1007 in order, none lost.
- Redirect with word in flight: redirect to 0x40 while the issue for 0xC is in flight and FIFO holds 0/4/8 -> next valid is `inst_pc`=0x40, `inst`=0x1010, then 0x44/0x1011. Words 0x1000..0x1003 never appear after R.
- Misaligned and simultaneous: redirect_pc=0x43 asserted on the same edge as `inst_ready`=1 with a valid head -> the head is not counted as consumed; next valid `inst_pc`=0x40.
- Wrap: RESET_PC=0xFFFF_FFF8 -> `inst_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Async reset mid-stream: drop `rst_n` between edges with `inst_valid`=1 -> `inst_valid`=0 immediately and `mem_write`=0. After release, the fetch restarts at RESET_PC with a 2-edge latency.
